// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, constants and helpers for the multi-digit BCD counter.
//   bcd_t      - one BCD decade (4 bits).
//   BCD_MAX    - largest legal decade value (9).
//   BCD_MIN    - smallest decade value (0).
//   bcd_sat()  - clamps a 4-bit value into the legal BCD range (min(v, 9)).
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  function automatic bcd_t bcd_sat(input bcd_t v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD decade of the counter.
// Ports:
//   clock   in  rising-edge clock
//   reset   in  asynchronous, active-high reset to 0
//   step    in  advance this decade on the next edge (already qualified
//               by enable and the lower-digit carry/borrow chain)
//   up      in  1 = increment, 0 = decrement
//   clear   in  synchronous clear to 0 (highest priority)
//   load    in  synchronous load of bcd_sat(d) (below clear, above step)
//   d       in  load value for this decade
//   q       out current decade value, always 0..9
//   is_max  out q == 9 (feeds the increment carry chain)
//   is_min  out q == 0 (feeds the decrement borrow chain)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic step,
  input  logic up,
  input  logic clear,
  input  logic load,
  input  bcd_t d,
  output bcd_t q,
  output logic is_max,
  output logic is_min
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= BCD_MIN;
    end else if (clear) begin
      q <= BCD_MIN;
    end else if (load) begin
      q <= bcd_sat(d);
    end else if (step) begin
      if (up) begin
        // >= rather than == keeps the digit legal even if it were ever
        // disturbed into 10..15: it falls straight back to 0.
        q <= (q >= BCD_MAX) ? BCD_MIN : bcd_t'(q + 4'd1);
      end else begin
        q <= (q == BCD_MIN) ? BCD_MAX : bcd_t'(q - 4'd1);
      end
    end
  end

  assign is_max = (q == BCD_MAX);
  assign is_min = (q == BCD_MIN);

endmodule

// File: rtl/bcd_counter.sv
// bcd_counter: DIGITS-decade BCD up/down counter with clear, terminal count
// and wrap flags.
// Optional feature macro: BCD_COUNTER_LOAD_EN adds the load/load_val ports
// and a synchronous parallel load (each digit saturated to 9).
// Ports:
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-high reset (cnt = 0, wrap = 0)
//   en        in   count enable, one step per enabled edge
//   up        in   direction, 1 = increment, 0 = decrement
//   clear     in   synchronous clear to all-zero, also drops wrap
//   load      in   synchronous load (BCD_COUNTER_LOAD_EN only)
//   load_val  in   4*DIGITS load value, digit 0 in [3:0] (BCD_COUNTER_LOAD_EN only)
//   cnt       out  4*DIGITS BCD count, digit 0 in [3:0]
//   tc        out  combinational: en high and the next step wraps
//   wrap      out  registered one-cycle pulse after a wrapping step
// Interface semantics: there is no handshake; cnt/tc/wrap are valid every
// cycle and every input is sampled on each rising edge (clear > load > en).
// DIGITS legal range is 1..8.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic                up,
  input  logic                clear,
`ifdef BCD_COUNTER_LOAD_EN
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
`endif
  output logic [4*DIGITS-1:0] cnt,
  output logic                tc,
  output logic                wrap
);

  logic [DIGITS-1:0] is_max;
  logic [DIGITS-1:0] is_min;
  logic [DIGITS-1:0] step;
  // chain[k] is high when every digit below k sits at its turnover value
  // for the current direction; chain[DIGITS] means the whole count does.
  logic [DIGITS:0]   chain;
  logic              load_i;
  logic [4*DIGITS-1:0] load_d;

`ifdef BCD_COUNTER_LOAD_EN
  assign load_i = load;
  assign load_d = load_val;
`else
  assign load_i = 1'b0;
  assign load_d = '0;
`endif

  assign chain[0] = 1'b1;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    // Look-ahead enable: each digit's step comes from the prefix AND of the
    // lower digits' flags, not from a rippled digit-to-digit carry.
    assign chain[k+1] = chain[k] & (up ? is_max[k] : is_min[k]);
    assign step[k]    = en & chain[k];

    bcd_digit u_digit (
      .clock  (clock),
      .reset  (reset),
      .step   (step[k]),
      .up     (up),
      .clear  (clear),
      .load   (load_i),
      .d      (load_d[4*k +: 4]),
      .q      (cnt[4*k +: 4]),
      .is_max (is_max[k]),
      .is_min (is_min[k])
    );
  end

  // clear and load deliberately do not gate tc.
  assign tc = en & chain[DIGITS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrap <= 1'b0;
    end else begin
      wrap <= tc & ~clear & ~load_i;
    end
  end

endmodule
